clk_div_prog: RTL and testbench



---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_ch.sv | 96 +++++++++
 rtl/clk_div_prog.sv | 37 +++
 tb/tb_clk_div_prog.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

   localparam int unsigned DIV_MIN  = 2;
   localparam int unsigned MAX_CH   = 16;
   localparam int unsigned CH_IDX_W = $clog2(MAX_CH);

   // Divisors below DIV_MIN cannot form a period with both levels, so raise them.
   function automatic logic [31:0] clamp_div(input logic [31:0] value);
      return (value < DIV_MIN) ? DIV_MIN : value;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, active/pending divisor and registered outputs.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic             sync_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             pend_o
);

   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             running_q, running_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;

   logic [CNT_W-1:0] n_eff;
   logic             boundary;

   always_comb begin
      phase_d    = phase_q;
      n_d        = n_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      running_d  = running_q;
      clk_out_d  = clk_out_q;
      tick_d     = tick_q;
      n_eff      = n_q;
      boundary   = 1'b0;

      if (!en_i) begin
         // An idle edge counts as a boundary so a pending divisor lands immediately.
         boundary  = 1'b1;
         running_d = 1'b0;
         phase_d   = '0;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
      end else begin
         boundary  = !running_q || sync_i || (phase_q == n_q - CNT_W'(1));
         running_d = 1'b1;
         phase_d   = boundary ? '0 : phase_q + CNT_W'(1);
      end

      if (boundary && pend_q) begin
         n_eff  = pend_val_q;
         n_d    = pend_val_q;
         pend_d = 1'b0;
      end

      if (en_i) begin
         tick_d    = boundary;
         clk_out_d = (phase_d < (n_eff >> 1));
      end

      // A load on a boundary edge only queues; it never takes effect on that edge.
      if (load_i) begin
         pend_val_d = CNT_W'(clamp_div(32'(div_i)));
         pend_d     = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         phase_q    <= '0;
         n_q        <= CNT_W'(DEFAULT_DIV);
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         running_q  <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         n_q        <= n_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         running_q  <= running_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;
   assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable integer clock divider with glitch-free divisor updates.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       load,
   input  logic [NUM_CH*CNT_W-1:0] div_in,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       pend
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i     (clk),
         .reset_i   (reset),
         .en_i      (en[i]),
         .load_i    (load[i]),
         .div_i     (div_in[i*CNT_W +: CNT_W]),
         .sync_i    (sync),
         .clk_out_o (clk_out[i]),
         .tick_o    (tick[i]),
         .pend_o    (pend[i])
      );
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog against a period-position reference model.
module tb_clk_div_prog;

   localparam int unsigned NUM_CH      = 4;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned DEFAULT_DIV = 3;

   logic                    clk;
   logic                    reset;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH-1:0]       load;
   logic [NUM_CH*CNT_W-1:0] div_in;
   logic                    sync;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       pend;

   clk_div_prog #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .load    (load),
      .div_in  (div_in),
      .sync    (sync),
      .clk_out (clk_out),
      .tick    (tick),
      .pend    (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Model: each channel knows its divisor and how many cycles into the current period it is.
   int unsigned m_n   [NUM_CH];
   int unsigned m_pv  [NUM_CH];
   bit          m_pend[NUM_CH];
   bit          m_run [NUM_CH];
   int unsigned m_k   [NUM_CH];
   logic [NUM_CH-1:0] exp_clk, exp_tick, exp_pend;

   function automatic int unsigned clamp_ref(input int unsigned v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic model_edge();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         bit start;
         if (reset) begin
            m_n[ch] = DEFAULT_DIV; m_pend[ch] = 0; m_run[ch] = 0; m_k[ch] = 0;
            exp_clk[ch] = 0; exp_tick[ch] = 0;
         end else begin
            if (!en[ch]) start = 1;
            else start = !m_run[ch] || sync || (m_k[ch] + 1 == m_n[ch]);
            if (start && m_pend[ch]) begin
               m_n[ch] = m_pv[ch];
               m_pend[ch] = 0;
            end
            if (load[ch]) begin
               m_pv[ch]   = clamp_ref(int'(div_in[ch*CNT_W +: CNT_W]));
               m_pend[ch] = 1;
            end
            if (!en[ch]) begin
               m_run[ch] = 0; m_k[ch] = 0; exp_clk[ch] = 0; exp_tick[ch] = 0;
            end else begin
               m_run[ch]    = 1;
               m_k[ch]      = start ? 0 : m_k[ch] + 1;
               exp_tick[ch] = (m_k[ch] == 0);
               exp_clk[ch]  = (m_k[ch] < m_n[ch] / 2);
            end
         end
         exp_pend[ch] = m_pend[ch];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("clk_out", 32'(clk_out), 32'(exp_clk));
      check("tick",    32'(tick),    32'(exp_tick));
      check("pend",    32'(pend),    32'(exp_pend));
   endtask

   initial begin
      reset = 1'b1; en = '0; load = '0; div_in = '0; sync = 1'b0;
      repeat (2) step();
      check("rst_outs", 32'({clk_out, tick, pend}), 32'h0);
      reset = 1'b0;

      // Default divisor 3: tick and clk_out both 1,0,0 repeating.
      en[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("dflt_tick", 32'(tick[0]),    32'(i % 3 == 0));
         check("dflt_clk",  32'(clk_out[0]), 32'(i % 3 == 0));
      end

      // Load 4 while idle, then enable: pend drops on the start edge, then 1,1,0,0.
      en[0] = 1'b0; step();
      load[0] = 1'b1; div_in[0 +: CNT_W] = 16'd4; step();
      check("idle_pend", 32'(pend[0]), 32'd1);
      load[0] = 1'b0; en[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("n4_pend", 32'(pend[0]),    32'd0);
         check("n4_clk",  32'(clk_out[0]), 32'(i % 4 < 2));
         check("n4_tick", 32'(tick[0]),    32'(i % 4 == 0));
      end

      // Loads of 0 then 1 both clamp to 2.
      load[0] = 1'b1; div_in[0 +: CNT_W] = 16'd0; step();
      div_in[0 +: CNT_W] = 16'd1; step();
      load[0] = 1'b0;
      en[0] = 1'b0; step();
      en[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("n2_clk", 32'(clk_out[0]), 32'(i % 2 == 0));
      end

      // Random traffic: enables toggle, sparse loads, syncs and resets.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         sync  = ($urandom_range(0, 39) == 0);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(0, 24) == 0) en[ch] = ~en[ch];
            load[ch] = ($urandom_range(0, 14) == 0);
            div_in[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 9));
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
